rv_multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the RV32I core.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Configures the immediate generator through imm_sel, and drives the datapath enables and muxes.
- Performs the request/ready handshake with the unified memory port, and flags unsupported opcodes with a sticky trap.

---
 rtl/rv_multicycle_ctrl.sv | 119 +++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for an RV32I core
module rv_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruction,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic [2:0]       imm_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             illegal
);
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  state_t state, next;
  logic [6:0] opc;
  logic is_op, is_opimm, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc, legal;
  logic unused_bits;

  assign opc         = instruction[6:0];
  assign unused_bits = ^instruction[31:7];
  assign is_op       = opc == OP;
  assign is_opimm    = opc == OP_IMM;
  assign is_load     = opc == LOAD;
  assign is_store    = opc == STORE;
  assign is_branch   = opc == BRANCH;
  assign is_jal      = opc == JAL;
  assign is_jalr     = opc == JALR;
  assign is_lui      = opc == LUI;
  assign is_auipc    = opc == AUIPC;
  assign legal       = is_op | is_opimm | is_load | is_store | is_branch | is_jal | is_jalr | is_lui | is_auipc;
  assign illegal     = state == TRAP;

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;

  always_ff @(posedge clk or posedge reset)
    if (reset) instret <= '0;
    else if (retire) instret <= instret + CNT_W'(1);

  always_comb begin
    next      = state;
    imm_sel   = 3'd0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = 2'd0;
    reg_we    = 1'b0;
    wb_sel    = 2'd0;
    retire    = 1'b0;
    if (state != IDLE && state != TRAP)
      imm_sel = is_store ? 3'd1 : is_branch ? 3'd2 : (is_lui | is_auipc) ? 3'd3 : is_jal ? 3'd4 : 3'd0;
    case (state)
      IDLE: next = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
        next    = mem_ready ? DECODE : FETCH;
      end
      DECODE: next = legal ? EXEC : TRAP;
      EXEC: begin
        alu_src_a = is_auipc;
        alu_src_b = is_opimm | is_load | is_store | is_jalr | is_lui | is_auipc;
        alu_op    = (is_op | is_opimm) ? 2'd1 : is_branch ? 2'd2 : is_lui ? 2'd3 : 2'd0;
        pc_we     = is_branch;
        pc_src    = {1'b0, is_branch & branch_taken};
        retire    = is_branch;
        next      = is_branch ? FETCH : (is_load | is_store) ? MEM : WB;
      end
      MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_store;
        pc_we    = mem_ready & is_store;
        retire   = mem_ready & is_store;
        next     = !mem_ready ? MEM : is_store ? FETCH : WB;
      end
      WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        retire = 1'b1;
        wb_sel = is_load ? 2'd1 : (is_jal | is_jalr) ? 2'd2 : 2'd0;
        pc_src = is_jal ? 2'd1 : is_jalr ? 2'd2 : 2'd0;
        next   = FETCH;
      end
      TRAP: next = TRAP;
      default: next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb_rv_multicycle_ctrl: directed per-cycle checks of the multi-cycle control FSM
module tb_rv_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = '0;
  logic        mem_ready = 1'b1;
  logic        branch_taken = 1'b0;
  logic [2:0]  imm_sel;
  logic        ir_we, pc_we, mem_req, mem_we, addr_sel, alu_src_a, alu_src_b, reg_we, retire, illegal;
  logic [1:0]  pc_src, alu_op, wb_sel;
  logic [31:0] instret;
  logic [17:0] obs;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rv_multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .imm_sel(imm_sel), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we),
    .wb_sel(wb_sel), .retire(retire), .instret(instret), .illegal(illegal)
  );

  assign obs = {imm_sel, ir_we, pc_we, pc_src, mem_req, mem_we, addr_sel,
                alu_src_a, alu_src_b, alu_op, reg_we, wb_sel, retire};

  function automatic logic [17:0] ev(input logic [2:0] imm, input logic irwe, input logic pcwe,
                                     input logic [1:0] pcs, input logic req, input logic we,
                                     input logic asel, input logic a, input logic b,
                                     input logic [1:0] aop, input logic rwe, input logic [1:0] wsel,
                                     input logic ret);
    return {imm, irwe, pcwe, pcs, req, we, asel, a, b, aop, rwe, wsel, ret};
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (obs !== 18'd0) begin bad++; $display("FAIL reset_outputs got %h want 0", obs); end
    total++;
    if (instret !== 32'd0 || illegal !== 1'b0) begin
      bad++; $display("FAIL reset_regs instret=%0d illegal=%b want 0 0", instret, illegal);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (obs !== 18'd0) begin bad++; $display("FAIL idle_outputs got %h want 0", obs); end
  endtask

  task automatic test_addi;
    logic [17:0] exp [4];
    exp[0] = ev(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    exp[1] = 18'd0;
    exp[2] = ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    exp[3] = ev(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) instruction = 32'h00A00093;
      mem_ready = 1'b1;
      #1;
      total++;
      if (obs !== exp[i]) begin bad++; $display("FAIL addi cyc%0d got %h want %h", i, obs, exp[i]); end
    end
    @(posedge clk);
    #1;
    total++;
    if (instret !== 32'd1) begin bad++; $display("FAIL addi_instret got %0d want 1", instret); end
  endtask

  task automatic test_jal;
    logic [17:0] exp [4];
    logic [17:0] m [4];
    exp[0] = ev(4, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    exp[1] = ev(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp[2] = ev(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp[3] = ev(4, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 2, 1);
    m[0] = '1; m[1] = '1; m[3] = '1;
    m[2] = 18'h3FF0F;  // ALU selects are don't-care while JAL is in EXEC
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) instruction = 32'hFF1FF0EF;
      mem_ready = 1'b1;
      #1;
      total++;
      if ((obs & m[i]) !== (exp[i] & m[i])) begin
        bad++; $display("FAIL jal cyc%0d got %h want %h", i, obs & m[i], exp[i] & m[i]);
      end
    end
    @(posedge clk);
    #1;
    total++;
    if (instret !== 32'd2) begin bad++; $display("FAIL jal_instret got %0d want 2", instret); end
  endtask

  task automatic test_branch;
    logic [17:0] exp [3];
    for (int t = 0; t < 2; t++) begin
      exp[0] = ev(2, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      exp[1] = ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      exp[2] = ev(2, 0, 1, (t == 0) ? 2'd1 : 2'd0, 0, 0, 0, 0, 0, 2, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (i == 0) instruction = 32'h00000063;
        mem_ready = 1'b1;
        branch_taken = (t == 0);
        #1;
        total++;
        if (obs !== exp[i]) begin bad++; $display("FAIL beq%0d cyc%0d got %h want %h", t, i, obs, exp[i]); end
      end
      @(posedge clk);
      #1;
      total++;
      if (instret !== 32'(3 + t)) begin bad++; $display("FAIL beq%0d_instret got %0d want %0d", t, instret, 3 + t); end
    end
    branch_taken = 1'b0;
  endtask

  task automatic test_load_wait;
    logic [17:0] exp [11];
    logic rdy [11];
    for (int i = 0; i < 11; i++) rdy[i] = 1'b0;
    rdy[3] = 1'b1;
    rdy[9] = 1'b1;
    for (int i = 0; i < 3; i++) exp[i] = ev(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    exp[3] = ev(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    exp[4] = 18'd0;
    exp[5] = ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 6; i < 10; i++) exp[i] = ev(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    exp[10] = ev(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == 0) instruction = 32'h00002083;
      mem_ready = rdy[i];
      #1;
      total++;
      if (obs !== exp[i]) begin bad++; $display("FAIL lw cyc%0d got %h want %h", i, obs, exp[i]); end
    end
    @(posedge clk);
    #1;
    total++;
    if (instret !== 32'd5) begin bad++; $display("FAIL lw_instret got %0d want 5", instret); end
  endtask

  task automatic test_store;
    logic [17:0] exp [4];
    exp[0] = ev(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    exp[1] = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp[2] = ev(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    exp[3] = ev(1, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) instruction = 32'h00102023;
      mem_ready = 1'b1;
      #1;
      total++;
      if (obs !== exp[i]) begin bad++; $display("FAIL sw cyc%0d got %h want %h", i, obs, exp[i]); end
    end
    @(posedge clk);
    #1;
    total++;
    if (instret !== 32'd6) begin bad++; $display("FAIL sw_instret got %0d want 6", instret); end
  endtask

  task automatic test_trap;
    logic [17:0] exp [5];
    exp[0] = ev(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 5; i++) exp[i] = 18'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) instruction = 32'h0000007F;
      mem_ready = 1'b1;
      #1;
      total++;
      if (obs !== exp[i] || illegal !== (i >= 2)) begin
        bad++; $display("FAIL trap cyc%0d got %h/%b want %h/%b", i, obs, illegal, exp[i], i >= 2);
      end
    end
    total++;
    if (instret !== 32'd6) begin bad++; $display("FAIL trap_instret got %0d want 6", instret); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (obs !== 18'd0 || illegal !== 1'b0 || instret !== 32'd0) begin
      bad++; $display("FAIL trap_reset got %h/%b/%0d want 0/0/0", obs, illegal, instret);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (obs !== 18'd0) begin bad++; $display("FAIL trap_idle got %h want 0", obs); end
  endtask

  task automatic test_reset_abort;
    logic [17:0] exp [4];
    exp[0] = ev(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    exp[1] = 18'd0;
    exp[2] = ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    exp[3] = ev(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) instruction = 32'h00002083;
      mem_ready = (i == 0);
      #1;
      total++;
      if (obs !== exp[i]) begin bad++; $display("FAIL abort cyc%0d got %h want %h", i, obs, exp[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      reset = 1'b1;
      mem_ready = 1'b1;
      #1;
      total++;
      if (obs !== 18'd0 || reg_we !== 1'b0) begin bad++; $display("FAIL abort_in_reset%0d got %h want 0", i, obs); end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (obs !== 18'd0) begin bad++; $display("FAIL abort_idle got %h want 0", obs); end
    @(negedge clk);
    #1;
    total++;
    if (obs !== exp[0] || instret !== 32'd0) begin
      bad++; $display("FAIL abort_refetch got %h/%0d want %h/0", obs, instret, exp[0]);
    end
  endtask

  initial begin
    test_reset;
    test_addi;
    test_jal;
    test_branch;
    test_load_wait;
    test_store;
    test_trap;
    test_reset_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
